mem_access_unit: RTL and testbench

Load/store stage sitting directly downstream of the single-cycle datapath. It consumes the datapath's memory address (ALU result) and store data (rs2), and returns the load data written back to the register file. It converts RISC-V byte, halfword and word accesses into word-aligned bus transactions with byte enables over a req/ack handshake. While an access is outstanding it holds the core with a stall, and it reports misaligned, illegal and timed-out accesses as faults.

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/halfword/word accesses into word-aligned bus transactions
// with byte enables, stalling the core until the bus acknowledges, faults or times out.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        lane_q, lane_d;

  logic        access;
  logic        legal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] lane_word;
  logic [31:0] load_val;

  assign access = mem_rd | mem_wr;
  assign stall  = access & (state_q != StDone);

  // Request decode: byte enables, lane-replicated store data and legality.
  always_comb begin
    be_calc    = 4'b0000;
    wdata_calc = 32'h0;
    legal      = 1'b1;
    case (func3)
      3'b000, 3'b100: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        be_calc    = 4'b0011 << {addr[1], 1'b0};
        wdata_calc = {2{wdata[15:0]}};
        if (addr[0]) legal = 1'b0;
      end
      3'b010: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        if (addr[1:0] != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (mem_rd && mem_wr) legal = 1'b0;
  end

  // Load extraction; halfwords are aligned so the byte-lane shift also picks the half.
  assign lane_word = bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_val = 32'h0;
    case (func3_q)
      3'b000:  load_val = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b100:  load_val = {24'h0, lane_word[7:0]};
      3'b001:  load_val = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b101:  load_val = {16'h0, lane_word[15:0]};
      3'b010:  load_val = bus_rdata;
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    func3_d     = func3_q;
    lane_d      = lane_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (access) begin
          if (legal) begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_calc;
            bus_wdata_d = wdata_calc;
            func3_d     = func3;
            lane_d      = addr[1:0];
            state_d     = StReq;
          end else begin
            fault_d = 1'b1;
            rdata_d = 32'h0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StReq: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          rdata_d   = bus_we_q ? 32'h0 : load_val;
          fault_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ToLast) begin
            bus_req_d = 1'b0;
            rdata_d   = 32'h0;
            fault_d   = 1'b1;
            done_d    = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      func3_q     <= 3'b000;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      func3_q     <= func3_d;
      lane_q      <= lane_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit, plus hand sequences for late ack
// after timeout and reset in the middle of a request.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, done, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  mem_access_unit #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .func3     (func3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          ack_wait;
    bit          no_ack;
    logic        exp_fault;
    int          exp_req;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] brd, input int ack_wait, input bit no_ack,
                              input logic ef, input int ereq, input logic [31:0] ebaddr,
                              input logic [3:0] ebe, input logic ewe,
                              input logic [31:0] ebwd, input logic [31:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.brdata = brd;
    v.ack_wait = ack_wait; v.no_ack = no_ack; v.exp_fault = ef; v.exp_req = ereq;
    v.exp_baddr = ebaddr; v.exp_be = ebe; v.exp_we = ewe; v.exp_bwdata = ebwd;
    v.exp_rdata = erd;
    return v;
  endfunction

  // Presents one access at a negedge and follows it to its done pulse.
  task automatic apply(input vec_t v, input string tag);
    int  req_n  = 0;
    int  stall_n = 0;
    bit  seen   = 1'b0;
    @(negedge clk);
    mem_rd = v.rd; mem_wr = v.wr; func3 = v.f3; addr = v.addr; wdata = v.wdata;
    bus_rdata = v.brdata; bus_ack = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall) stall_n++;
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          chk({tag, " bus_addr"}, bus_addr, v.exp_baddr);
          chk({tag, " bus_be"}, {28'h0, bus_be}, {28'h0, v.exp_be});
          chk({tag, " bus_we"}, {31'h0, bus_we}, {31'h0, v.exp_we});
          if (v.exp_we) chk({tag, " bus_wdata"}, bus_wdata, v.exp_bwdata);
        end
        bus_ack = !v.no_ack && (req_n == v.ack_wait + 1);
      end else begin
        bus_ack = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " done_seen"}, {31'h0, seen}, 32'h1);
    if (seen) begin
      chk({tag, " fault"}, {31'h0, fault}, {31'h0, v.exp_fault});
      chk({tag, " rdata"}, rdata, v.exp_rdata);
      chk({tag, " stall_in_done"}, {31'h0, stall}, 32'h0);
      chk({tag, " stall_cycles"}, stall_n, 1 + v.exp_req);
      chk({tag, " req_cycles"}, req_n, v.exp_req);
    end
    mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, " done_pulse"}, {31'h0, done}, 32'h0);
    chk({tag, " rdata_hold"}, rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; func3 = 3'b000; addr = 32'h0;
    wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

    vecs.push_back(mk(1, 0, 3'b010, 32'h104, 0, 32'hDEADBEEF, 2, 0, 0, 3, 32'h104, 4'hF, 0,
                      0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 3'b000, 32'h203, 0, 32'h80FF1234, 0, 0, 0, 1, 32'h200, 4'h8, 0,
                      0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 0, 3'b100, 32'h203, 0, 32'h80FF1234, 0, 0, 0, 1, 32'h200, 4'h8, 0,
                      0, 32'h00000080));
    vecs.push_back(mk(0, 1, 3'b001, 32'h12, 32'hAAAA5678, 0, 0, 0, 0, 1, 32'h10, 4'hC, 1,
                      32'h56785678, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h31, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h206, 0, 32'h80011234, 1, 0, 0, 2, 32'h204, 4'hC, 0,
                      0, 32'hFFFF8001));
    vecs.push_back(mk(1, 0, 3'b101, 32'h204, 0, 32'h80019234, 0, 0, 0, 1, 32'h204, 4'h3, 0,
                      0, 32'h00009234));
    vecs.push_back(mk(0, 1, 3'b010, 32'h40, 32'h12345678, 0, 1, 0, 0, 2, 32'h40, 4'hF, 1,
                      32'h12345678, 0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h41, 32'h000000A5, 0, 0, 0, 0, 1, 32'h40, 4'h2, 1,
                      32'hA5A5A5A5, 0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h201, 0, 32'h80FF1234, 0, 0, 0, 1, 32'h200, 4'h2, 0,
                      0, 32'h00000012));
    vecs.push_back(mk(1, 0, 3'b010, 32'h300, 0, 32'h55555555, 0, 1, 1, 4, 32'h300, 4'hF, 0,
                      0, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst bus_we", {31'h0, bus_we}, 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst fault", {31'h0, fault}, 32'h0);
    chk("rst stall", {31'h0, stall}, 32'h0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // A late ack after the timeout must not produce another completion.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_ack = 1'b1;
      #1;
      chk($sformatf("late_ack%0d done", i), {31'h0, done}, 32'h0);
      chk($sformatf("late_ack%0d bus_req", i), {31'h0, bus_req}, 32'h0);
      chk($sformatf("late_ack%0d fault", i), {31'h0, fault}, 32'h1);
    end
    @(negedge clk);
    bus_ack = 1'b0;

    // Reset while a request is outstanding.
    mem_rd = 1'b1; func3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    #1;
    chk("mid_rst bus_req_before", {31'h0, bus_req}, 32'h1);
    rst = 1'b1; mem_rd = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst bus_req", {31'h0, bus_req}, 32'h0);
    chk("mid_rst done", {31'h0, done}, 32'h0);
    chk("mid_rst fault", {31'h0, fault}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d done", i), {31'h0, done}, 32'h0);
      chk($sformatf("post_rst%0d bus_req", i), {31'h0, bus_req}, 32'h0);
    end
    apply(mk(0, 1, 3'b000, 32'h0, 32'h7F, 0, 0, 0, 0, 1, 32'h0, 4'h1, 1, 32'h7F7F7F7F, 0),
          "sb_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
